move_entry_ctrl: RTL



---
 rtl/move_entry_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/move_entry_ctrl.sv
// move_entry_ctrl: keypad move-entry sequencer (X digit, Y digit, confirm/pass) with editing and inactivity timeout.
// Ports: clk/rst_n (async active-low); start requests an entry; kb_en/key_index/key_valid/key_ready
// talk to the keypad scanner; move_x/move_y/move_pass/move_valid/move_ready present the finished move;
// busy, stage and timeout are status outputs. All outputs come from registered state only.
module move_entry_ctrl #(
  parameter int BOARD_SIZE     = 9,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       kb_en,
  input  logic [3:0] key_index,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [3:0] move_x,
  output logic [3:0] move_y,
  output logic       move_pass,
  output logic       move_valid,
  input  logic       move_ready,
  output logic       busy,
  output logic [1:0] stage,
  output logic       timeout
);
  typedef enum logic [2:0] {IDLE, GET_X, GET_Y, CONFIRM, OUTPUT} state_t;
  localparam logic [3:0] BS = 4'(BOARD_SIZE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  state_t state, state_nxt;
  logic [3:0] x_nxt, y_nxt;
  logic pass_nxt, to_nxt, active, acc, digit, expire;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  assign active     = state inside {GET_X, GET_Y, CONFIRM};
  assign kb_en      = active;
  assign key_ready  = active;
  assign move_valid = state == OUTPUT;
  assign busy       = state != IDLE;
  assign stage      = state == GET_X ? 2'd1 : state == GET_Y ? 2'd2 : state == CONFIRM ? 2'd3 : 2'd0;
  assign acc        = key_valid && active;
  // codes below BOARD_SIZE are digits; BOARD_SIZE <= 12 keeps them disjoint from the command codes
  assign digit      = key_index < BS;
  // an accepted key in the expiry cycle wins, so expiry requires !acc
  assign expire     = TIMEOUT_CYCLES > 0 && active && !acc && cnt == LAST;
  always_comb begin
    state_nxt = state;
    x_nxt     = move_x;
    y_nxt     = move_y;
    pass_nxt  = move_pass;
    to_nxt    = 1'b0;
    cnt_nxt   = acc ? '0 : active ? cnt + CNT_W'(1) : cnt;
    case (state)
      IDLE: if (start) begin
        state_nxt = GET_X;
        x_nxt     = '0;
        y_nxt     = '0;
        pass_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
      GET_X: if (acc) begin
        if (digit) begin
          x_nxt     = key_index;
          state_nxt = GET_Y;
        end else if (key_index == 4'd14) begin
          pass_nxt  = 1'b1;
          state_nxt = OUTPUT;
        end
      end
      GET_Y: if (acc) begin
        if (digit) begin
          y_nxt     = key_index;
          state_nxt = CONFIRM;
        end else if (key_index == 4'd12 || key_index == 4'd13) begin
          state_nxt = GET_X;
        end else if (key_index == 4'd14) begin
          pass_nxt  = 1'b1;
          state_nxt = OUTPUT;
        end
      end
      CONFIRM: if (acc && !digit) begin
        if (key_index == 4'd15) begin
          state_nxt = OUTPUT;
        end else if (key_index == 4'd12) begin
          state_nxt = GET_Y;
        end else if (key_index == 4'd13) begin
          state_nxt = GET_X;
        end else if (key_index == 4'd14) begin
          pass_nxt  = 1'b1;
          state_nxt = OUTPUT;
        end
      end
      OUTPUT: if (move_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (expire) begin
      state_nxt = IDLE;
      x_nxt     = '0;
      y_nxt     = '0;
      pass_nxt  = 1'b0;
      cnt_nxt   = '0;
      to_nxt    = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      move_x    <= '0;
      move_y    <= '0;
      move_pass <= 1'b0;
      cnt       <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      move_x    <= x_nxt;
      move_y    <= y_nxt;
      move_pass <= pass_nxt;
      cnt       <= cnt_nxt;
      timeout   <= to_nxt;
    end
  end
endmodule
